// File: rtl/sd_pkg.sv
// sd_pkg: shared SD-over-SPI types and constants for the init and block-read sequencers.
package sd_pkg;
    typedef enum logic [3:0] {
        RD_IDLE,
        RD_SEND_CMD,
        RD_WAIT_R1,
        RD_POLL_TOKEN,
        RD_WAIT_TOKEN,
        RD_READ_BYTE,
        RD_WAIT_BYTE,
        RD_READ_CRC,
        RD_WAIT_CRC,
        RD_DONE,
        RD_ERROR
    } rd_state_t;

    typedef enum logic [2:0] {
        ERR_NONE,
        ERR_R1,
        ERR_TIMEOUT,
        ERR_TOKEN,
        ERR_SPI,
        ERR_NOT_READY
    } rd_err_t;

    localparam logic [7:0] CMD17_IDX  = 8'h51;
    localparam logic [7:0] DATA_TOKEN = 8'hFE;
    localparam logic [7:0] DUMMY_CRC  = 8'hFF;
endpackage

// File: rtl/sd_block_reader.sv
// sd_block_reader: CMD17 single-block read sequencer driving the shared SPI command engine.
module sd_block_reader
    import sd_pkg::*;
#(
    parameter int BLOCK_BYTES   = 512,
    parameter int TOKEN_TIMEOUT = 1024,
    parameter int CNT_W         = 11
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        sd_ready,
    input  logic        sd_hc,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    output logic        rd_busy,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        rd_done,
    output logic        rd_error,
    output logic [2:0]  rd_err_code,
    output logic        spi_cmd,
    output logic [47:0] spi_cmd_data,
    output logic [9:0]  spi_response_len,
    output logic        spi_rd,
    input  logic        spi_busy,
    input  logic        spi_error,
    input  logic [7:0]  spi_response,
    input  logic        spi_avail
);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BLOCK_BYTES - 1);
    localparam logic [CNT_W-1:0] POLL_MAX  = CNT_W'(TOKEN_TIMEOUT);

    rd_state_t        state;
    rd_err_t          fail_code;
    logic [31:0]      addr;
    logic [31:0]      arg;
    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] poll_cnt;
    logic [CNT_W-1:0] poll_nxt;
    logic             crc_cnt;
    logic             wait_st;
    logic             fail;

    // SDSC cards take a byte address; high block bits simply wrap away
    assign arg      = sd_hc ? addr : {addr[22:0], 9'b0};
    assign poll_nxt = poll_cnt + 1'b1;
    assign wait_st  = state inside {RD_WAIT_R1, RD_WAIT_TOKEN, RD_WAIT_BYTE, RD_WAIT_CRC};
    assign fail     = fail_code != ERR_NONE;

    // every abort path funnels through one code; spi_error outranks a coincident byte
    always_comb begin
        fail_code = ERR_NONE;
        if (state == RD_IDLE)
            fail_code = (rd_req && !sd_ready) ? ERR_NOT_READY : ERR_NONE;
        else if (wait_st && spi_error)
            fail_code = ERR_SPI;
        else if (spi_avail && state == RD_WAIT_R1)
            fail_code = (spi_response != 8'h00) ? ERR_R1 : ERR_NONE;
        else if (spi_avail && state == RD_WAIT_TOKEN)
            fail_code = (spi_response == DATA_TOKEN) ? ERR_NONE :
                        (spi_response != 8'hFF)      ? ERR_TOKEN :
                        (poll_nxt == POLL_MAX)       ? ERR_TIMEOUT : ERR_NONE;
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state            <= RD_IDLE;
            addr             <= '0;
            byte_cnt         <= '0;
            poll_cnt         <= '0;
            crc_cnt          <= 1'b0;
            rd_busy          <= 1'b0;
            rd_data          <= '0;
            rd_valid         <= 1'b0;
            rd_done          <= 1'b0;
            rd_error         <= 1'b0;
            rd_err_code      <= '0;
            spi_cmd          <= 1'b0;
            spi_cmd_data     <= '0;
            spi_response_len <= '0;
            spi_rd           <= 1'b0;
        end else begin
            spi_cmd  <= 1'b0;
            spi_rd   <= 1'b0;
            rd_valid <= 1'b0;
            rd_done  <= 1'b0;
            rd_error <= 1'b0;
            if (fail) begin
                state       <= (fail_code == ERR_NOT_READY) ? RD_IDLE : RD_ERROR;
                rd_err_code <= fail_code;
                rd_error    <= 1'b1;
                rd_busy     <= 1'b0;
            end else begin
                case (state)
                    RD_IDLE: if (rd_req && sd_ready && !spi_busy) begin
                        addr        <= rd_addr;
                        rd_err_code <= ERR_NONE;
                        rd_busy     <= 1'b1;
                        state       <= RD_SEND_CMD;
                    end
                    RD_SEND_CMD: if (!spi_busy) begin
                        spi_cmd          <= 1'b1;
                        spi_cmd_data     <= {CMD17_IDX, arg, DUMMY_CRC};
                        spi_response_len <= 10'd1;
                        state            <= RD_WAIT_R1;
                    end
                    RD_WAIT_R1: if (spi_avail) begin
                        poll_cnt <= '0;
                        state    <= RD_POLL_TOKEN;
                    end
                    RD_POLL_TOKEN, RD_READ_BYTE, RD_READ_CRC: if (!spi_busy) begin
                        spi_rd <= 1'b1;
                        state  <= (state == RD_POLL_TOKEN) ? RD_WAIT_TOKEN :
                                  (state == RD_READ_BYTE)  ? RD_WAIT_BYTE : RD_WAIT_CRC;
                    end
                    RD_WAIT_TOKEN: if (spi_avail) begin
                        byte_cnt <= '0;
                        poll_cnt <= poll_nxt;
                        state    <= (spi_response == DATA_TOKEN) ? RD_READ_BYTE : RD_POLL_TOKEN;
                    end
                    RD_WAIT_BYTE: if (spi_avail) begin
                        rd_data  <= spi_response;
                        rd_valid <= 1'b1;
                        byte_cnt <= byte_cnt + 1'b1;
                        crc_cnt  <= 1'b0;
                        state    <= (byte_cnt == LAST_BYTE) ? RD_READ_CRC : RD_READ_BYTE;
                    end
                    RD_WAIT_CRC: if (spi_avail) begin
                        crc_cnt <= 1'b1;
                        rd_done <= crc_cnt;
                        rd_busy <= !crc_cnt;
                        state   <= crc_cnt ? RD_DONE : RD_READ_CRC;
                    end
                    default: state <= RD_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sd_block_reader.sv
// tb_sd_block_reader: directed checks of CMD17 block reads against a small SPI engine model.
module tb_sd_block_reader;
    logic        clk = 1'b0;
    logic        res_n, sd_ready, sd_hc, rd_req;
    logic [31:0] rd_addr;
    logic        rd_busy, rd_valid, rd_done, rd_error;
    logic [7:0]  rd_data;
    logic [2:0]  rd_err_code;
    logic        spi_cmd, spi_rd, spi_busy, spi_error, spi_avail;
    logic [47:0] spi_cmd_data;
    logic [9:0]  spi_response_len;
    logic [7:0]  spi_response;

    int tests = 0, fails = 0;
    int cmd_cnt = 0, rd_cnt = 0, done_cnt = 0, err_cnt = 0, viol = 0;
    int cyc = 0, avail_cyc = 0, done_gap = 0, mstep = 0;
    int d0, e0, rd0, cmd0;
    logic        busy_at_done;
    logic [47:0] last_cmd;
    logic [9:0]  last_len;
    logic [8:0]  e;
    logic [8:0]  q[$];
    logic [7:0]  got[$];

    sd_block_reader dut (
        .clk(clk), .res_n(res_n), .sd_ready(sd_ready), .sd_hc(sd_hc),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_busy(rd_busy), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_done(rd_done), .rd_error(rd_error),
        .rd_err_code(rd_err_code), .spi_cmd(spi_cmd), .spi_cmd_data(spi_cmd_data),
        .spi_response_len(spi_response_len), .spi_rd(spi_rd), .spi_busy(spi_busy),
        .spi_error(spi_error), .spi_response(spi_response), .spi_avail(spi_avail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // SPI engine: busy one cycle after a launch, answer from q (bit 8 = fault), stay busy one extra cycle
    initial begin
        spi_busy = 0; spi_error = 0; spi_avail = 0; spi_response = 0;
        forever begin
            @(posedge clk);
            #1;
            spi_avail = 0;
            spi_error = 0;
            if (!res_n) begin
                mstep = 0;
                spi_busy = 0;
            end else if (mstep == 0) begin
                if (spi_cmd) begin cmd_cnt++; last_cmd = spi_cmd_data; last_len = spi_response_len; mstep = 1; end
                if (spi_rd) begin rd_cnt++; mstep = 1; end
            end else if (mstep == 1) begin
                spi_busy = 1;
                mstep = 2;
            end else if (mstep == 2) begin
                e = (q.size() > 0) ? q.pop_front() : 9'h0FF;
                spi_response = e[7:0];
                spi_avail = !e[8];
                spi_error = e[8];
                mstep = 3;
            end else if (mstep == 3) begin
                mstep = 4;
            end else begin
                spi_busy = 0;
                mstep = 0;
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (rd_valid) got.push_back(rd_data);
        if (spi_avail) avail_cyc = cyc;
        if (rd_done) begin done_cnt++; done_gap = cyc - avail_cyc; busy_at_done = rd_busy; end
        if (rd_error) err_cnt++;
        if ((spi_cmd && spi_rd) || ((spi_cmd || spi_rd) && spi_busy)) viol++;
    end

    task automatic start(input logic [31:0] a, input logic hc, input logic rdy);
        d0 = done_cnt; e0 = err_cnt; rd0 = rd_cnt; cmd0 = cmd_cnt;
        got.delete();
        @(negedge clk);
        sd_hc = hc; sd_ready = rdy; rd_addr = a; rd_req = 1;
        @(negedge clk);
        rd_req = 0;
        check("busy_after_req", rd_busy, rdy);
        if (rdy) check("code_cleared", rd_err_code, 0);
    endtask

    task automatic run(input logic [31:0] a, input logic hc, input logic rdy);
        start(a, hc, rdy);
        for (int i = 0; i < 10000 && done_cnt == d0 && err_cnt == e0; i++) @(negedge clk);
        check("finished", (done_cnt != d0) || (err_cnt != e0), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic load_block();
        q.delete();
        q.push_back(9'h000);
        repeat (3) q.push_back(9'h0FF);
        q.push_back(9'h0FE);
        for (int i = 0; i < 512; i++) q.push_back({1'b0, 8'(i)});
        q.push_back(9'h0AB);
        q.push_back(9'h0CD);
    endtask

    task automatic check_block();
        int bad = 0;
        for (int i = 0; i < got.size(); i++) if (got[i] != 8'(i)) bad++;
        check("blk_len", got.size(), 512);
        check("blk_data_bad", bad, 0);
        check("blk_done", done_cnt - d0, 1);
        check("blk_no_err", err_cnt - e0, 0);
        check("blk_busy_idle", rd_busy, 0);
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_strobes"}, {rd_busy, rd_valid, rd_done, rd_error, spi_cmd, spi_rd}, 0);
        check({pfx, "_rd_data"}, rd_data, 0);
        check({pfx, "_err_code"}, rd_err_code, 0);
        check({pfx, "_cmd_data"}, spi_cmd_data, 0);
        check({pfx, "_resp_len"}, spi_response_len, 0);
    endtask

    initial begin
        res_n = 0; rd_req = 0; rd_addr = 0; sd_hc = 1; sd_ready = 1;
        repeat (3) @(negedge clk);
        check_reset("rst");
        res_n = 1;
        repeat (2) @(negedge clk);

        load_block();
        run(32'h0000_0010, 1'b1, 1'b1);
        check("hc_cmd_data", last_cmd, 48'h51_0000_0010_FF);
        check("hc_resp_len", last_len, 1);
        check("hc_rd_pulses", rd_cnt - rd0, 518);
        check("hc_done_gap", done_gap, 1);
        check("hc_busy_at_done", busy_at_done, 0);
        check_block();

        q.delete();
        q.push_back(9'h000);
        q.push_back(9'h008);
        run(32'h0000_0003, 1'b0, 1'b1);
        check("sc_cmd_data", last_cmd, 48'h51_0000_0600_FF);
        check("tok_code", rd_err_code, 3);
        check("tok_err_pulse", err_cnt - e0, 1);
        check("tok_rd_pulses", rd_cnt - rd0, 1);

        q.delete();
        q.push_back(9'h004);
        run(32'h0000_0020, 1'b1, 1'b1);
        check("r1_code", rd_err_code, 1);
        check("r1_no_spi_rd", rd_cnt - rd0, 0);
        check("r1_one_cmd", cmd_cnt - cmd0, 1);
        check("r1_idle", rd_busy, 0);

        q.delete();
        q.push_back(9'h000);
        run(32'h0000_0030, 1'b1, 1'b1);
        check("tmo_code", rd_err_code, 2);
        check("tmo_rd_pulses", rd_cnt - rd0, 1024);
        check("tmo_no_done", done_cnt - d0, 0);

        q.delete();
        q.push_back(9'h000);
        q.push_back(9'h0FE);
        for (int i = 0; i < 100; i++) q.push_back({1'b0, 8'(i)});
        q.push_back(9'h100);
        run(32'h0000_0040, 1'b1, 1'b1);
        check("spierr_code", rd_err_code, 4);
        check("spierr_no_done", done_cnt - d0, 0);
        check("spierr_bytes", got.size(), 100);

        q.delete();
        run(32'h0000_0050, 1'b1, 1'b0);
        check("nrdy_code", rd_err_code, 5);
        check("nrdy_no_cmd", cmd_cnt - cmd0, 0);
        check("nrdy_err_pulse", err_cnt - e0, 1);

        load_block();
        start(32'h0000_0060, 1'b1, 1'b1);
        for (int i = 0; i < 5000 && got.size() < 200; i++) @(negedge clk);
        check("mid_reached_200", got.size(), 200);
        res_n = 0;
        #1;
        check_reset("mid_rst");
        repeat (2) @(negedge clk);
        res_n = 1;
        q.delete();
        check("mid_no_done", done_cnt - d0, 0);
        check("mid_no_err", err_cnt - e0, 0);
        repeat (3) @(negedge clk);

        load_block();
        run(32'h0000_0070, 1'b1, 1'b1);
        check("post_cmd_data", last_cmd, 48'h51_0000_0070_FF);
        check_block();

        check("protocol_viol", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
